cmac_dot_engine: RTL

Pipelined complex multiply-accumulate engine for the matrix datapath: it consumes a stream of complex operand pairs and accumulates `len` complex products per dot product. It runs `n_dots` dot products back-to-back and writes each result into an internal result RAM at an auto-incrementing address. It supersedes the fixed single-product multiply/sum chain with parametrised widths, vector length and result depth, a valid/ready input handshake, and job control.

---
 rtl/cmac_dot_engine.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cmac_dot_engine.sv
// cmac_dot_engine: pipelined complex multiply-accumulate dot-product engine.
// Result saturation is enabled by defining CMAC_SAT_EN (default: wrap).
module cmac_dot_engine #(
   parameter int DATA_W   = 32,
   parameter int FRAC_IN  = 27,
   parameter int OUT_W    = 32,
   parameter int FRAC_OUT = 21,
   parameter int LEN_W    = 6,
   parameter int RES_AW   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [RES_AW-1:0] n_dots,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_re,
   input  logic [DATA_W-1:0] a_im,
   input  logic [DATA_W-1:0] b_re,
   input  logic [DATA_W-1:0] b_im,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_re,
   output logic [OUT_W-1:0]  out_im,
   output logic [RES_AW-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic              sat_flag,
   input  logic [RES_AW-1:0] rd_addr,
   output logic [OUT_W-1:0]  rd_re,
   output logic [OUT_W-1:0]  rd_im
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = 2 * DATA_W + 1;
   localparam int ACC_W  = SUM_W + LEN_W;
   localparam int SH     = 2 * FRAC_IN - FRAC_OUT;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state_q, state_d;

   logic              accept;
   logic              fire;
   logic              last_beat;
   logic              last_dot;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  beat_cnt;
   logic [RES_AW-1:0] ndots_q;
   logic [RES_AW-1:0] dot_cnt;

   logic                     s0_v, s0_first, s0_last, s0_final;
   logic signed [DATA_W-1:0] ar_q, ai_q, br_q, bi_q;
   logic                     s1_v, s1_first, s1_last, s1_final;
   logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic                     s2_v, s2_first, s2_last, s2_final;
   logic signed [SUM_W-1:0]  sum_re, sum_im;
   logic                     s3_v, s3_last, s3_final;
   logic signed [ACC_W-1:0]  acc_re, acc_im;
   logic                     out_final;

   logic signed [ACC_W-1:0] sh_re, sh_im;
   logic [OUT_W:0]          cv_re, cv_im;
   logic                    sat_hit;
   logic                    res_evt;

   logic [OUT_W-1:0] ram_re [0:(1<<RES_AW)-1];
   logic [OUT_W-1:0] ram_im [0:(1<<RES_AW)-1];

   // Reduce a shifted accumulator to OUT_W bits; MSB of result is the clamp flag.
   function automatic logic [OUT_W:0] reduce(input logic signed [ACC_W-1:0] v);
`ifdef CMAC_SAT_EN
      if (&v[ACC_W-1:OUT_W-1] || ~|v[ACC_W-1:OUT_W-1])
         return {1'b0, v[OUT_W-1:0]};
      else if (v[ACC_W-1])
         return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      else
         return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
`else
      return {1'b0, v[OUT_W-1:0]};
`endif
   endfunction

   assign accept    = start && (state_q == IDLE) &&
                      (len != '0) && (n_dots != '0);
   assign fire      = in_valid && in_ready;
   assign last_beat = (beat_cnt == len_q - LEN_W'(1));
   assign last_dot  = (dot_cnt == ndots_q - RES_AW'(1));

   assign sh_re   = acc_re >>> SH;
   assign sh_im   = acc_im >>> SH;
   assign cv_re   = reduce(sh_re);
   assign cv_im   = reduce(sh_im);
   assign sat_hit = cv_re[OUT_W] | cv_im[OUT_W];
   assign res_evt = s3_v && s3_last;

   // Job state register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state and handshake/status decode.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_d = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            if (fire && last_beat && last_dot) state_d = DRAIN;
         end
         DRAIN: begin
            if (out_valid && out_final) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Job parameters and beat/dot counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q    <= '0;
         ndots_q  <= '0;
         beat_cnt <= '0;
         dot_cnt  <= '0;
      end else if (accept) begin
         len_q    <= len;
         ndots_q  <= n_dots;
         beat_cnt <= '0;
         dot_cnt  <= '0;
      end else if (fire) begin
         if (last_beat) begin
            beat_cnt <= '0;
            dot_cnt  <= dot_cnt + RES_AW'(1);
         end else begin
            beat_cnt <= beat_cnt + LEN_W'(1);
         end
      end
   end

   // Operand, product and sum stages; tags follow the data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_v <= 1'b0; s0_first <= 1'b0;
         s0_last <= 1'b0; s0_final <= 1'b0;
         ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
         s1_v <= 1'b0; s1_first <= 1'b0;
         s1_last <= 1'b0; s1_final <= 1'b0;
         p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
         s2_v <= 1'b0; s2_first <= 1'b0;
         s2_last <= 1'b0; s2_final <= 1'b0;
         sum_re <= '0; sum_im <= '0;
      end else begin
         s0_v     <= fire;
         s0_first <= (beat_cnt == '0);
         s0_last  <= last_beat;
         s0_final <= last_beat && last_dot;
         if (fire) begin
            ar_q <= a_re; ai_q <= a_im;
            br_q <= b_re; bi_q <= b_im;
         end
         s1_v <= s0_v; s1_first <= s0_first;
         s1_last <= s0_last; s1_final <= s0_final;
         p_rr <= ar_q * br_q;
         p_ii <= ai_q * bi_q;
         p_ri <= ar_q * bi_q;
         p_ir <= ai_q * br_q;
         s2_v <= s1_v; s2_first <= s1_first;
         s2_last <= s1_last; s2_final <= s1_final;
         sum_re <= SUM_W'(p_rr) - SUM_W'(p_ii);
         sum_im <= SUM_W'(p_ri) + SUM_W'(p_ir);
      end
   end

   // Accumulate; first term of a dot loads, bubbles hold the partial sum.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s3_v <= 1'b0; s3_last <= 1'b0; s3_final <= 1'b0;
         acc_re <= '0; acc_im <= '0;
      end else begin
         s3_v     <= s2_v;
         s3_last  <= s2_last;
         s3_final <= s2_final;
         if (s2_v) begin
            if (s2_first) begin
               acc_re <= ACC_W'(sum_re);
               acc_im <= ACC_W'(sum_im);
            end else begin
               acc_re <= acc_re + ACC_W'(sum_re);
               acc_im <= acc_im + ACC_W'(sum_im);
            end
         end
      end
   end

   // Converted result, write address and sticky clamp flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_final <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_addr  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= res_evt;
         if (res_evt) begin
            out_re    <= cv_re[OUT_W-1:0];
            out_im    <= cv_im[OUT_W-1:0];
            out_final <= s3_final;
         end
         if (accept)         out_addr <= '0;
         else if (out_valid) out_addr <= out_addr + RES_AW'(1);
         if (accept)                  sat_flag <= 1'b0;
         else if (res_evt && sat_hit) sat_flag <= 1'b1;
      end
   end

   // Result RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && out_valid) begin
         ram_re[out_addr] <= out_re;
         ram_im[out_addr] <= out_im;
      end
   end

   // Registered read port; same-address write returns old data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_re <= '0;
         rd_im <= '0;
      end else begin
         rd_re <= ram_re[rd_addr];
         rd_im <= ram_im[rd_addr];
      end
   end

endmodule
